hmac_verify: RTL and testbench

- Receiving end of the HMAC-SHA3-256 link: recomputes the MAC over a received key/message pair and checks it against a received tag.
- Sequences an external SHA3-256 core through four 1088-bit blocks: inner (key^ipad, message) and outer (key^opad, padded inner hash).
- Compares the final digest with the tag in constant time and reports done/match.
- Sits beside the MAC generator on the receive path, sharing the same hash-core handshake.

---
 rtl/hmac_verify_if.sv | 19 +
 rtl/hmac_verify.sv | 163 ++++++++++++++++
 tb/tb_hmac_verify.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hmac_verify_if.sv
// Hash-core handshake bundle: the verifier presents 1088-bit blocks and collects 256-bit digests.
interface hmac_verify_if;
  logic [1087:0] hash_in;
  logic          hash_more;
  logic          hash_in_valid;
  logic [255:0]  hash_out;
  logic          hash_next;
  logic          hash_out_valid;

  modport master (
    output hash_in, hash_more, hash_in_valid,
    input  hash_out, hash_next, hash_out_valid
  );

  modport slave (
    input  hash_in, hash_more, hash_in_valid,
    output hash_out, hash_next, hash_out_valid
  );
endinterface

// File: rtl/hmac_verify.sv
// HMAC-SHA3-256 verifier: drives an external SHA3 core over 4 blocks, compares with tag in constant time (HMAC_VERIFY_LOCK_EN adds lockout).
// Latency 2*NCH+1 cycles plus core time, data-independent; the core paces blocks via hash_next/hash_out_valid.
module hmac_verify #(
  parameter int CHUNK_W  = 272,
  parameter int MAX_FAIL = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1087:0] key,
  input  logic [1087:0] message,
  input  logic [255:0]  tag,
  output logic          busy,
  output logic          done,
  output logic          match,
  output logic          locked,
  hmac_verify_if.master core
);

  localparam int RATE = 1088;
  localparam int NCH  = RATE / CHUNK_W;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK_W % 8 != 0 || RATE % CHUNK_W != 0 || MAX_FAIL < 1) begin : g_bad_param
    $error("hmac_verify: CHUNK_W must be a byte multiple dividing 1088 and MAX_FAIL >= 1");
  end

  typedef enum logic [2:0] {IDLE, XOR_I, HASH_I, XOR_O, HASH_O, CMP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1087:0]   key_q, msg_q;
  logic [255:0]    tag_q, inner, mac;
  logic [1087:0]   hash_in_q;
  logic            hash_more_q, hash_in_valid_q;

  logic            accept, last_chunk, diff;
  logic [1087:0]   key_sel;
  logic [7:0]      pad;
  logic [CHUNK_W-1:0] chunk_raw, chunk_rev;

  assign core.hash_in       = hash_in_q;
  assign core.hash_more     = hash_more_q;
  assign core.hash_in_valid = hash_in_valid_q;

  assign accept     = (state == IDLE) && start && !locked;
  assign last_chunk = (cnt == CW'(NCH - 1));
  // Full-width reduction, no early exit: compare time never depends on the data.
  assign diff       = |(mac ^ tag_q);

  function automatic logic [255:0] flip_bytes(input logic [255:0] d);
    logic [255:0] r;
    r = '0;
    for (int b = 0; b < 32; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = d[8*b+7-i];
    return r;
  endfunction

  // Chunk 0 comes straight from the key port in the accept cycle, later chunks from the latch.
  always_comb begin
    key_sel   = (state == IDLE) ? key : key_q;
    pad       = (state == XOR_O) ? 8'h5c : 8'h36;
    chunk_raw = key_sel[cnt*CHUNK_W +: CHUNK_W] ^ {(CHUNK_W/8){pad}};
    chunk_rev = '0;
    for (int b = 0; b < CHUNK_W/8; b++)
      for (int i = 0; i < 8; i++)
        chunk_rev[8*b+i] = chunk_raw[8*b+7-i];
  end

`ifdef HMAC_VERIFY_LOCK_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic [FW-1:0] fail_cnt;
  logic          locked_q;
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      key_q           <= '0;
      msg_q           <= '0;
      tag_q           <= '0;
      inner           <= '0;
      mac             <= '0;
      hash_in_q       <= '0;
      hash_more_q     <= 1'b0;
      hash_in_valid_q <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      match           <= 1'b0;
`ifdef HMAC_VERIFY_LOCK_EN
      fail_cnt        <= '0;
      locked_q        <= 1'b0;
`endif
    end else begin
      hash_in_valid_q <= 1'b0;
      done            <= 1'b0;
      case (state)
        IDLE, XOR_I, XOR_O: begin
          if (state != IDLE || accept) begin
            if (state == IDLE) begin
              key_q <= key;
              msg_q <= message;
              tag_q <= tag;
              match <= 1'b0;
              busy  <= 1'b1;
            end
            hash_in_q[cnt*CHUNK_W +: CHUNK_W] <= chunk_rev;
            if (last_chunk) begin
              cnt             <= '0;
              hash_in_valid_q <= 1'b1;
              hash_more_q     <= 1'b1;
              state           <= (state == XOR_O) ? HASH_O : HASH_I;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= (state == XOR_O) ? XOR_O : XOR_I;
            end
          end
        end
        HASH_I: begin
          if (core.hash_out_valid) begin
            inner <= flip_bytes(core.hash_out);
            state <= XOR_O;
          end else if (core.hash_next && !hash_in_valid_q) begin
            hash_in_q       <= msg_q;
            hash_in_valid_q <= 1'b1;
            hash_more_q     <= 1'b0;
          end
        end
        HASH_O: begin
          if (core.hash_out_valid) begin
            mac   <= core.hash_out;
            state <= CMP;
          end else if (core.hash_next && !hash_in_valid_q) begin
            hash_in_q       <= {inner, 3'b011, 828'd0, 1'b1};
            hash_in_valid_q <= 1'b1;
            hash_more_q     <= 1'b0;
          end
        end
        CMP: begin
          match <= ~diff;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef HMAC_VERIFY_LOCK_EN
          if (diff) begin
            if (fail_cnt != FW'(MAX_FAIL)) fail_cnt <= fail_cnt + 1'b1;
            if (fail_cnt == FW'(MAX_FAIL - 1)) locked_q <= 1'b1;
          end else begin
            fail_cnt <= '0;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_verify.sv
// Randomized bench for hmac_verify: a stand-in core (cheap mixing digest, not SHA3) and a block-level reference model.
module tb_hmac_verify;

  localparam int NCH      = 4;
  localparam int MAX_FAIL = 3;
`ifdef HMAC_VERIFY_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1087:0] key = '0, message = '0;
  logic [255:0]  tag = '0;
  logic          busy, done, match, locked;

  hmac_verify_if hif();

  hmac_verify #(.CHUNK_W(272), .MAX_FAIL(MAX_FAIL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .message(message), .tag(tag),
    .busy(busy), .done(done), .match(match), .locked(locked), .core(hif)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  int   dbl = 0, done_cnt = 0, fails = 0;
  logic prev_hiv = 1'b0;

  always @(negedge clk) begin
    if (hif.hash_in_valid && prev_hiv) dbl++;
    prev_hiv = hif.hash_in_valid;
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [1087:0] got, input logic [1087:0] exp);
    int lo;
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      lo = 0;
      for (int i = 1087; i >= 0; i--) if (got[i] !== exp[i]) lo = i;
      lo = (lo / 64) * 64;
      $display("FAIL %s: got[%0d+:64]=%h expected %h", name, lo, got[lo +: 64], exp[lo +: 64]);
    end
  endtask

  // Key XOR pad, each byte bit-reversed in place.
  function automatic logic [1087:0] pad_blk(input logic [1087:0] k, input logic [7:0] p);
    logic [1087:0] r;
    logic [7:0]    b;
    for (int j = 0; j < 136; j++) begin
      b = k[8*j +: 8] ^ p;
      for (int i = 0; i < 8; i++) r[8*j+i] = b[7-i];
    end
    return r;
  endfunction

  function automatic logic [255:0] flip256(input logic [255:0] d);
    logic [255:0] r;
    for (int j = 0; j < 32; j++)
      for (int i = 0; i < 8; i++) r[8*j+i] = d[8*j+7-i];
    return r;
  endfunction

  function automatic logic [255:0] toy(input logic [1087:0] b0, input logic [1087:0] b1);
    logic [1087:0] x;
    x = b0 ^ {b1[1086:0], b1[1087]};
    return x[255:0] ^ x[511:256] ^ x[767:512] ^ x[1023:768] ^ {192'd0, x[1087:1024]} ^ 256'h9e3779b9;
  endfunction

  function automatic logic [1087:0] final_blk(input logic [1087:0] k, input logic [1087:0] m);
    return {flip256(toy(pad_blk(k, 8'h36), m)), 3'b011, 828'd0, 1'b1};
  endfunction

  function automatic logic [255:0] model_mac(input logic [1087:0] k, input logic [1087:0] m);
    return toy(pad_blk(k, 8'h5c), final_blk(k, m));
  endfunction

  function automatic logic [1087:0] rand1088();
    logic [1087:0] r;
    for (int i = 0; i < 34; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic pulse(input logic nxt, input logic ov, input logic [255:0] d);
    @(negedge clk);
    hif.hash_next = nxt; hif.hash_out_valid = ov; hif.hash_out = d;
    @(negedge clk);
    hif.hash_next = 1'b0; hif.hash_out_valid = 1'b0;
  endtask

  task automatic wait_hiv(output int n);
    n = 0;
    while (!hif.hash_in_valid && n < 64) begin @(negedge clk); n++; end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 64) begin @(negedge clk); n++; end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    fails = 0;
  endtask

  // mode 0 normal, 1 next/digest collision, 2 start and stray strobes while busy, 3 reset during HASH_O
  task automatic run_one(input logic [1087:0] k, input logic [1087:0] m, input logic [255:0] t,
                         input int mode, output int lat);
    logic [1087:0] ba, bb, bc, bd;
    logic          exp_match;
    int            n, d0;
    time           t0;
    exp_match = (t == model_mac(k, m));
    d0 = done_cnt;
    lat = 0;
    @(negedge clk); key = k; message = m; tag = t; start = 1'b1;
    @(negedge clk); start = 1'b0; t0 = $time;
    chk("busy_after_start", busy, 1);
    if (mode == 2) begin
      start = 1'b1; key = rand1088(); message = rand1088(); tag = {8{$urandom}};
      hif.hash_next = 1'b1; hif.hash_out_valid = 1'b1;
      @(negedge clk); hif.hash_next = 1'b0; hif.hash_out_valid = 1'b0;
    end
    wait_hiv(n);
    chk("xor_i_cycles", n, (mode == 2) ? NCH - 2 : NCH - 1);
    ba = hif.hash_in;
    chk("blk0_key_ipad", ba, pad_blk(k, 8'h36));
    chk("more0", hif.hash_more, 1);
    if (mode == 1) pulse(1'b1, 1'b1, toy(ba, m));
    else begin
      repeat (2) @(negedge clk);
      pulse(1'b1, 1'b0, '0);
      wait_hiv(n); chk("blk1_wait", n, 0);
      bb = hif.hash_in;
      chk("blk1_message", bb, m);
      chk("more1", hif.hash_more, 0);
      repeat (2) @(negedge clk);
      pulse(1'b0, 1'b1, toy(ba, bb));
    end
    wait_hiv(n);
    chk("xor_o_cycles", n, NCH);
    bc = hif.hash_in;
    chk("blk2_key_opad", bc, pad_blk(k, 8'h5c));
    chk("more2", hif.hash_more, 1);
    if (mode == 3) begin
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_outputs", {busy, done, match, locked, hif.hash_in_valid, hif.hash_more}, 0);
      chk("rst_hash_in", hif.hash_in, 0);
      @(negedge clk); rst_n = 1'b1; fails = 0;
      chk("rst_no_done", done_cnt - d0, 0);
    end else begin
      repeat (2) @(negedge clk);
      pulse(1'b1, 1'b0, '0);
      wait_hiv(n); chk("blk3_wait", n, 0);
      bd = hif.hash_in;
      chk("blk3_final", bd, final_blk(k, m));
      chk("more3", hif.hash_more, 0);
      repeat (2) @(negedge clk);
      pulse(1'b0, 1'b1, toy(bc, bd));
      wait_done(n);
      chk("done_cycles", n, 1);
      lat = int'(($time - t0) / 10);
      start = 1'b0;
      chk("match", match, exp_match);
      chk("busy_at_done", busy, 0);
      fails = exp_match ? 0 : fails + 1;
      chk("locked", locked, LOCK_EN && fails >= MAX_FAIL);
      repeat (3) @(negedge clk);
      chk("one_done", done_cnt - d0, 1);
      chk("match_held", match, exp_match);
    end
  endtask

  initial begin
    logic [1087:0] k, m;
    logic [255:0]  mac;
    int            lat_p, lat;

    hif.hash_next = 1'b0; hif.hash_out_valid = 1'b0; hif.hash_out = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, match, locked, hif.hash_in_valid, hif.hash_more}, 0);
    chk("reset_hash_in", hif.hash_in, 0);
    rst_n = 1'b1;

    // Empty key, padded empty message: pass, then tag bit 0 flipped.
    k = '0; m = '0; m[7:0] = 8'h06; m[1087:1080] = 8'h80;
    mac = model_mac(k, m);
    run_one(k, m, mac, 0, lat_p);
    run_one(k, m, mac ^ 256'h1, 0, lat);
    chk("latency_pass_vs_fail", lat, lat_p);

    k = rand1088(); m = rand1088();
    run_one(k, m, model_mac(k, m), 1, lat);
    k = rand1088(); m = rand1088();
    run_one(k, m, model_mac(k, m), 2, lat);
    k = rand1088(); m = rand1088();
    run_one(k, m, model_mac(k, m), 3, lat);
    k = rand1088(); m = rand1088();
    run_one(k, m, model_mac(k, m), 0, lat);
    chk("latency_after_reset", lat, lat_p);

    // Alternate good and bad tags so the fail streak never reaches the lockout limit.
    for (int i = 0; i < 6; i++) begin
      k = rand1088(); m = rand1088();
      mac = model_mac(k, m);
      if (i % 2 == 0) mac[$urandom_range(255)] ^= 1'b1;
      run_one(k, m, mac, 0, lat);
      chk("latency_random", lat, lat_p);
    end

    chk("hash_in_valid_single", dbl, 0);

    if (LOCK_EN) begin
      do_reset();
      for (int i = 0; i < MAX_FAIL; i++) begin
        k = rand1088(); m = rand1088();
        run_one(k, m, ~model_mac(k, m), 0, lat);
      end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      chk("locked_start_ignored", busy, 0);
      chk("locked_held", locked, 1);
      do_reset();
      chk("reset_clears_lock", locked, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
